// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: splits 32-bit loads, stores and fetches into
// 8-bit RAM cycles and holds the pipeline until each transfer completes.
module mem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_write_type,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [31:0]               mem_wdata,
    output logic [31:0]               mem_data,
    output logic                      mem_done,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic [31:0]               inst_o,
    output logic                      if_done,
    output logic                      stall_req,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      ram_wr,
    output logic [7:0]                ram_dout,
    input  logic [7:0]                ram_din
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t                state_q, state_d;
    logic                  owner_inst_q, owner_inst_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            n_q, n_d;
    logic [2:0]            count_q, count_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [23:0]           lanes_q, lanes_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic [31:0]           inst_q, inst_d;
    logic                  mem_done_q, mem_done_d;
    logic                  if_done_q, if_done_d;

    logic                  data_wr_req;
    logic                  issuing;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  unused_addr_bits;

    assign data_wr_req = mem_write && (mem_write_type != 2'd0);

    always_comb begin
        state_d      = state_q;
        owner_inst_d = owner_inst_q;
        base_d       = base_q;
        n_d          = n_q;
        count_d      = count_q;
        wdata_d      = wdata_q;
        lanes_d      = lanes_q;
        mem_data_d   = mem_data_q;
        inst_d       = inst_q;
        mem_done_d   = 1'b0;
        if_done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = 3'd0;
                if (data_wr_req) begin
                    state_d      = WR;
                    owner_inst_d = 1'b0;
                    base_d       = mem_addr;
                    wdata_d      = mem_wdata;
                    case (mem_write_type)
                        2'd1:    n_d = 3'd1;
                        2'd2:    n_d = 3'd2;
                        default: n_d = 3'd4;
                    endcase
                end else if (mem_read) begin
                    state_d      = RD;
                    owner_inst_d = 1'b0;
                    base_d       = mem_addr;
                end else if (if_req) begin
                    state_d      = RD;
                    owner_inst_d = 1'b1;
                    base_d       = if_addr;
                end
            end
            RD: begin
                // RAM data lags its address by one cycle, so lane k lands while count is k+1
                case (count_q)
                    3'd1:    lanes_d[7:0]   = ram_din;
                    3'd2:    lanes_d[15:8]  = ram_din;
                    3'd3:    lanes_d[23:16] = ram_din;
                    default: ;
                endcase
                if (count_q == 3'd4) begin
                    state_d = DONE;
                    count_d = 3'd0;
                    if (owner_inst_q) begin
                        inst_d    = {ram_din, lanes_q};
                        if_done_d = 1'b1;
                    end else begin
                        mem_data_d = {ram_din, lanes_q};
                        mem_done_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            WR: begin
                if (count_q == n_q - 3'd1) begin
                    state_d    = DONE;
                    count_d    = 3'd0;
                    mem_done_d = 1'b1;
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_inst_q <= 1'b0;
            base_q       <= '0;
            n_q          <= 3'd0;
            count_q      <= 3'd0;
            wdata_q      <= 32'd0;
            lanes_q      <= 24'd0;
            mem_data_q   <= 32'd0;
            inst_q       <= 32'd0;
            mem_done_q   <= 1'b0;
            if_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_inst_q <= owner_inst_d;
            base_q       <= base_d;
            n_q          <= n_d;
            count_q      <= count_d;
            wdata_q      <= wdata_d;
            lanes_q      <= lanes_d;
            mem_data_q   <= mem_data_d;
            inst_q       <= inst_d;
            mem_done_q   <= mem_done_d;
            if_done_q    <= if_done_d;
        end
    end

    assign issuing          = ((state_q == RD) && (count_q != 3'd4)) || (state_q == WR);
    assign issue_addr       = base_q + {{(ADDR_WIDTH-3){1'b0}}, count_q};
    assign unused_addr_bits = ^issue_addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH];

    assign ram_addr = issuing ? issue_addr[RAM_ADDR_WIDTH-1:0] : '0;
    assign ram_wr   = (state_q == WR);

    always_comb begin
        ram_dout = 8'd0;
        if (state_q == WR) begin
            case (count_q[1:0])
                2'd0:    ram_dout = wdata_q[7:0];
                2'd1:    ram_dout = wdata_q[15:8];
                2'd2:    ram_dout = wdata_q[23:16];
                default: ram_dout = wdata_q[31:24];
            endcase
        end
    end

    // Gated by reset so the pipeline is released the moment reset asserts
    assign stall_req = rst && ((state_q == RD) || (state_q == WR) ||
                       ((state_q == IDLE) && (mem_read || data_wr_req || if_req)));

    assign mem_data = mem_data_q;
    assign mem_done = mem_done_q;
    assign inst_o   = inst_q;
    assign if_done  = if_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-array RAM plus a golden memory model
// predict every address, write, completion time and assembled word.
module tb_mem_ctrl;

    localparam int AW  = 32;
    localparam int RAW = 17;
    localparam int RAM_SIZE = 1 << RAW;
    localparam logic [31:0] MASK = 32'h1FFFF;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            mem_read = 1'b0;
    logic            mem_write = 1'b0;
    logic [1:0]      mem_write_type = 2'd0;
    logic [AW-1:0]   mem_addr = '0;
    logic [31:0]     mem_wdata = '0;
    logic [31:0]     mem_data;
    logic            mem_done;
    logic            if_req = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic [31:0]     inst_o;
    logic            if_done;
    logic            stall_req;
    logic [RAW-1:0]  ram_addr;
    logic            ram_wr;
    logic [7:0]      ram_dout;
    logic [7:0]      ram_din = 8'd0;

    logic [7:0] ram  [0:RAM_SIZE-1];
    logic [7:0] gold [0:RAM_SIZE-1];

    int checks = 0;
    int errors = 0;

    mem_ctrl #(.ADDR_WIDTH(AW), .RAM_ADDR_WIDTH(RAW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_write_type(mem_write_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_data(mem_data), .mem_done(mem_done),
        .if_req(if_req), .if_addr(if_addr), .inst_o(inst_o), .if_done(if_done),
        .stall_req(stall_req), .ram_addr(ram_addr), .ram_wr(ram_wr),
        .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM: read data appears one cycle after its address
    always @(posedge clk) begin
        if (ram_wr) ram[ram_addr] <= ram_dout;
        ram_din <= ram[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] gold_word(input logic [31:0] addr);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = gold[(addr + i) & MASK];
        return w;
    endfunction

    task automatic clear_inputs();
        mem_read = 0; mem_write = 0; mem_write_type = 0; if_req = 0;
    endtask

    // One request from IDLE; the requester holds it until its done pulse
    task automatic access(input bit is_fetch, input bit is_store, input logic [1:0] wtype,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int n, lat, done_at;
        logic [31:0] exp_word, old_data;
        n   = !is_store ? 4 : (wtype == 2'd1) ? 1 : (wtype == 2'd2) ? 2 : 4;
        lat = is_store ? n + 1 : 6;
        old_data = mem_data;
        exp_word = gold_word(addr);
        mem_read = !is_store && !is_fetch;
        mem_write = is_store; mem_write_type = wtype; mem_addr = addr; mem_wdata = wdata;
        if_req = is_fetch; if_addr = addr;
        #1;
        check("stall_at_T", {31'd0, stall_req}, 32'd1);
        done_at = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k <= n) begin
                check("ram_addr", {15'd0, ram_addr}, (addr + k - 1) & MASK);
                check("ram_wr", {31'd0, ram_wr}, {31'd0, is_store});
                if (is_store) check("ram_dout", {24'd0, ram_dout}, {24'd0, wdata[8*(k-1) +: 8]});
            end else if (k < lat) begin
                check("ram_idle_addr", {15'd0, ram_addr}, 32'd0);
            end
            if (is_fetch ? if_done : mem_done) begin
                done_at = k;
                break;
            end
            check("stall_busy", {31'd0, stall_req}, 32'd1);
        end
        check("done_latency", done_at, lat);
        check("stall_done", {31'd0, stall_req}, 32'd0);
        if (is_store) begin
            for (int i = 0; i < n; i++) gold[(addr + i) & MASK] = wdata[8*i +: 8];
        end else if (is_fetch) begin
            check("inst_o", inst_o, exp_word);
            check("mem_data_held", mem_data, old_data);
        end else begin
            check("mem_data", mem_data, exp_word);
        end
        clear_inputs();
        step();
        check("done_pulse_1cyc", {30'd0, mem_done, if_done}, 32'd0);
    endtask

    initial begin
        int data_at, if_at;
        logic [7:0] b23;
        for (int i = 0; i < RAM_SIZE; i++) begin
            ram[i] = 8'($urandom);
            gold[i] = ram[i];
        end

        #12;
        check("reset_outputs", {mem_data ^ inst_o, 26'd0, mem_done, if_done, stall_req, ram_wr,
                                ram_dout != 0, ram_addr != 0}, 32'd0);
        rst = 1;
        step();

        // Directed load with known bytes
        ram[16] = 8'h11; ram[17] = 8'h22; ram[18] = 8'h33; ram[19] = 8'h44;
        for (int i = 16; i < 20; i++) gold[i] = ram[i];
        access(0, 0, 2'd0, 32'h10, 32'h0);
        check("load_0x10_const", mem_data, 32'h44332211);

        // sh at odd address must not disturb the third byte
        b23 = ram[35];
        access(0, 1, 2'd2, 32'h21, 32'hDEADBEEF);
        check("sh_byte0", {24'd0, ram[33]}, 32'hEF);
        check("sh_byte1", {24'd0, ram[34]}, 32'hBE);
        check("sh_untouched", {24'd0, ram[35]}, {24'd0, b23});

        access(0, 1, 2'd1, 32'h40, 32'h01020304);
        check("sb_only_byte", {24'd0, ram[64]}, 32'h04);
        check("sb_next_kept", {24'd0, ram[65]}, {24'd0, gold[65]});
        access(0, 1, 2'd3, 32'h40, 32'h01020304);
        access(0, 0, 2'd0, 32'h40, 32'h0);
        check("sw_readback", mem_data, 32'h01020304);

        // Type-0 write is ignored
        mem_write = 1; mem_write_type = 2'd0; mem_addr = 32'h50;
        #1;
        check("type0_no_stall", {31'd0, stall_req}, 32'd0);
        step();
        check("type0_no_wr", {31'd0, ram_wr}, 32'd0);
        clear_inputs();

        // Data beats fetch; fetch held and served afterwards
        mem_read = 1; mem_addr = 32'h10; if_req = 1; if_addr = 32'h40;
        data_at = -1; if_at = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (mem_done && data_at < 0) begin
                data_at = k;
                mem_read = 0;
            end
            if (k == 7) check("stall_fetch_idle", {31'd0, stall_req}, 32'd1);
            if (if_done) begin
                if_at = k;
                break;
            end
        end
        clear_inputs();
        check("arb_data_done", data_at, 6);
        check("arb_if_done", if_at, 13);
        check("arb_inst", inst_o, 32'h01020304);
        check("arb_mem_data_kept", mem_data, 32'h44332211);
        step();

        // Reset in the middle of an sw
        mem_write = 1; mem_write_type = 2'd3; mem_addr = 32'h80; mem_wdata = 32'hA1B2C3D4;
        step();
        step();
        rst = 0;
        #1;
        check("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        check("rst_mem_data", mem_data, 32'd0);
        clear_inputs();
        step();
        step();
        rst = 1;
        step();
        gold[128] = 8'hD4;
        check("rst_first_byte", {24'd0, ram[128]}, 32'hD4);
        check("rst_second_kept", {24'd0, ram[129]}, {24'd0, gold[129]});
        access(0, 0, 2'd0, 32'h80, 32'h0);

        // Wrapping addresses
        access(0, 0, 2'd0, 32'hFFFFFFFE, 32'h0);
        access(0, 1, 2'd3, 32'hFFFFFFFF, 32'hCAFEF00D);
        access(1, 0, 2'd0, 32'hFFFFFFFF, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 12; i++) begin
            int kind;
            logic [31:0] a;
            kind = int'($urandom_range(0, 2));
            a = $urandom;
            if (kind == 2) access(0, 1, 2'($urandom_range(1, 3)), a, $urandom);
            else access(kind == 1, 0, 2'd0, a, 32'h0);
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] a;
            a = $urandom & MASK;
            check("ram_vs_model", {24'd0, ram[a]}, {24'd0, gold[a]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
